// File: rtl/iob_axi_mem_responder.sv
// iob_axi_mem_responder
// AXI4 subordinate backed by on-chip register memory. Stands in for the DDR
// controller's AXI bridge in DDR-less FPGA builds and simulation.
// INCR/FIXED bursts, one outstanding transaction per direction, independent
// read and write channels (the memory is effectively dual-port).
//
// Optional feature macro: IOB_AXI_MEM_ERR_EN
//   defined   - SLVERR on WRAP/reserved bursts, size>2, or a wlast that does
//               not line up with the counted last beat; errored writes are
//               consumed but not committed, errored reads return zero data.
//   undefined - responses always OKAY, WRAP/reserved behave as INCR, wlast
//               is ignored.
module iob_axi_mem_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    // write address
    input  logic [AXI_ID_W-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // write data
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // write response
    output logic [AXI_ID_W-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // read address
    input  logic [AXI_ID_W-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // read data
    output logic [AXI_ID_W-1:0]   s_axi_rid,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         MEM_WORDS   = 2 ** MEM_ADDR_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // Next beat address: FIXED stays put, everything else steps by the beat
    // size and wraps at the top of the AXI address space (no 4KB check).
    function automatic logic [AXI_ADDR_W-1:0] f_next(
        input logic [AXI_ADDR_W-1:0] a,
        input logic [2:0]            sz,
        input logic [1:0]            bu
    );
        if (bu == BURST_FIXED) return a;
        return a + (AXI_ADDR_W'(1) << sz);
    endfunction

`ifdef IOB_AXI_MEM_ERR_EN
    // WRAP (2'b10) and reserved (2'b11) both have bit 1 set.
    function automatic logic f_cmd_err(input logic [1:0] bu, input logic [2:0] sz);
        return bu[1] || (sz > 3'd2);
    endfunction
`endif

    // Storage: not reset, upper address bits alias onto the same words.
    logic [31:0] r_mem [0:MEM_WORDS-1];

    // ---------------- write channel state ----------------
    wstate_t               r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [AXI_ID_W-1:0]   r_bid;
    logic [AXI_ADDR_W-1:0] r_awaddr;
    logic [7:0]            r_awlen;
    logic [2:0]            r_awsize;
    logic [1:0]            r_awburst;
    logic [7:0]            r_wcnt;
    logic                  r_werr;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wlast_exp;
    logic                  w_aw_err;
    logic                  w_beat_err;
    logic                  w_mem_we;
    logic [MEM_ADDR_W-1:0] w_widx;

    assign w_aw_hs     = r_awready & s_axi_awvalid;
    assign w_w_hs      = r_wready & s_axi_wvalid;
    // The burst length is taken from awlen; wlast is only cross-checked.
    assign w_wlast_exp = (r_wcnt == r_awlen);
    assign w_widx      = r_awaddr[MEM_ADDR_W+1:2];

`ifdef IOB_AXI_MEM_ERR_EN
    assign w_aw_err   = f_cmd_err(s_axi_awburst, s_axi_awsize);
    // Once a burst has gone bad, every remaining beat is dropped too.
    assign w_beat_err = r_werr | (s_axi_wlast != w_wlast_exp);
`else
    assign w_aw_err   = 1'b0;
    assign w_beat_err = r_werr;
`endif

    assign w_mem_we = w_w_hs & ~w_beat_err;

    // Write FSM: accept AW, consume counted W beats, hold B until taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_bid     <= s_axi_awid;
                        r_awaddr  <= s_axi_awaddr;
                        r_awlen   <= s_axi_awlen;
                        r_awsize  <= s_axi_awsize;
                        r_awburst <= s_axi_awburst;
                        r_wcnt    <= '0;
                        r_werr    <= w_aw_err;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_awaddr <= f_next(r_awaddr, r_awsize, r_awburst);
                        r_wcnt   <= r_wcnt + 8'd1;
                        r_werr   <= w_beat_err;
                        if (w_wlast_exp) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-enabled memory write port.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) r_mem[w_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel state ----------------
    rstate_t               r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic [AXI_ID_W-1:0]   r_rid;
    logic [AXI_ADDR_W-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic [7:0]            r_rcnt;
    logic                  r_rerr;

    logic                  w_ar_hs;
    logic                  w_ar_err;
    logic [AXI_ADDR_W-1:0] w_rnext_addr;
    logic [MEM_ADDR_W-1:0] w_ar_idx;
    logic [MEM_ADDR_W-1:0] w_rn_idx;

    assign w_ar_hs      = r_arready & s_axi_arvalid;
    assign w_rnext_addr = f_next(r_araddr, r_arsize, r_arburst);
    assign w_ar_idx     = s_axi_araddr[MEM_ADDR_W+1:2];
    assign w_rn_idx     = w_rnext_addr[MEM_ADDR_W+1:2];

`ifdef IOB_AXI_MEM_ERR_EN
    assign w_ar_err = f_cmd_err(s_axi_arburst, s_axi_arsize);
`else
    assign w_ar_err = 1'b0;
`endif

    // Read FSM: the first beat is fetched straight off the AR handshake so
    // rvalid rises one cycle later; further beats load whenever the output
    // register is empty or being drained, giving one beat per cycle.
    // Reading with non-blocking semantics means a same-cycle write to the
    // same word is not visible (old data is returned).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rcnt    <= '0;
            r_rerr    <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid     <= s_axi_arid;
                        r_araddr  <= s_axi_araddr;
                        r_arlen   <= s_axi_arlen;
                        r_arsize  <= s_axi_arsize;
                        r_arburst <= s_axi_arburst;
                        r_rcnt    <= '0;
                        r_rerr    <= w_ar_err;
                        r_rdata   <= w_ar_err ? 32'd0 : r_mem[w_ar_idx];
                        r_rresp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
                        r_rlast   <= (s_axi_arlen == 8'd0);
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (!r_rvalid || s_axi_rready) begin
                        if (r_rvalid && r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_araddr <= w_rnext_addr;
                            r_rcnt   <= r_rcnt + 8'd1;
                            r_rdata  <= r_rerr ? 32'd0 : r_mem[w_rn_idx];
                            r_rlast  <= ((r_rcnt + 8'd1) == r_arlen);
                            r_rvalid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bid     = r_bid;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rid     = r_rid;

    // Sideband fields carry nothing this memory needs.
    logic w_unused;
    assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                        s_axi_wlast};

endmodule

// File: tb/tb_iob_axi_mem_responder.sv
// Scoreboard bench for iob_axi_mem_responder: stimulus tasks push expected
// B/R responses into queues, a negedge monitor pops and compares them.
module tb_iob_axi_mem_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [0:0]  s_axi_awid = '0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [0:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [0:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = '0;
    logic [1:0]  s_axi_arburst = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [0:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;

    iob_axi_mem_responder dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

`ifdef IOB_AXI_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [0:0]  id;
    } rexp_t;

    typedef struct {
        logic [1:0] resp;
        logic [0:0] id;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    logic [31:0] wd[8];
    logic [3:0]  ws[8];
    logic [31:0] ed[8];
    logic        pat[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Issue one write burst using wd/ws; expected B response is queued first.
    task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [0:0] id, input logic [1:0] resp);
        int    n;
        bexp_t be;
        be.resp = resp;
        be.id   = id;
        bq.push_back(be);
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awburst = burst;
        s_axi_awsize  = 3'd2;
        s_axi_awid    = id;
        s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 50);
        if (!s_axi_awready) begin
            chk("aw_timeout", 32'd0, 32'd1);
            s_axi_awvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        chk("wready_after_aw", 32'(s_axi_wready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wd[i];
            s_axi_wstrb  = ws[i];
            s_axi_wlast  = (i == int'(len));
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_wready && n < 50);
            if (!s_axi_wready) begin
                chk("w_timeout", 32'd0, 32'd1);
                s_axi_wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        chk("bvalid_after_wlast", 32'(s_axi_bvalid), 32'd1);
    endtask

    // Issue one read burst; expected beats come from ed.
    task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [0:0] id, input logic [1:0] resp);
        int    n;
        rexp_t re;
        for (int i = 0; i <= int'(len); i++) begin
            re.data = ed[i];
            re.last = (i == int'(len));
            re.resp = resp;
            re.id   = id;
            rq.push_back(re);
        end
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arsize  = 3'd2;
        s_axi_arid    = id;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 50);
        if (!s_axi_arready) begin
            chk("ar_timeout", 32'd0, 32'd1);
            s_axi_arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        chk("rvalid_after_ar", 32'(s_axi_rvalid), 32'd1);
    endtask

    task automatic wait_b();
        int n = 0;
        while (bq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("b_drain", 32'(bq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_r();
        int n = 0;
        while (rq.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("r_drain", 32'(rq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: compare every accepted B and R beat against the scoreboard.
    always @(negedge clk) begin
        bexp_t mb;
        rexp_t mr;
        if (resetn && s_axi_bvalid && s_axi_bready) begin
            if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
            else begin
                mb = bq.pop_front();
                chk("bresp", 32'(s_axi_bresp), 32'(mb.resp));
                chk("bid", 32'(s_axi_bid), 32'(mb.id));
            end
        end
        if (resetn && s_axi_rvalid && s_axi_rready) begin
            if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
            else begin
                mr = rq.pop_front();
                chk("rdata", s_axi_rdata, mr.data);
                chk("rlast", 32'(s_axi_rlast), 32'(mr.last));
                chk("rresp", 32'(s_axi_rresp), 32'(mr.resp));
                chk("rid", 32'(s_axi_rid), 32'(mr.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_wready",  32'(s_axi_wready),  32'd0);
        chk("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        chk("rst_rlast",   32'(s_axi_rlast),   32'd0);
        chk("rst_rdata",   s_axi_rdata,        32'd0);
        chk("rst_resp",    32'({s_axi_bresp, s_axi_rresp}), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("awready_before_edge", 32'(s_axi_awready), 32'd0);
        @(posedge clk); #1;
        chk("awready_after_rst", 32'(s_axi_awready), 32'd1);
        chk("arready_after_rst", 32'(s_axi_arready), 32'd1);

        // ---- single write then read ----
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        wr(32'h10, 8'd0, 2'b01, 1'b1, 2'b00);
        wait_b();
        ed[0] = 32'hDEADBEEF;
        rd(32'h10, 8'd0, 2'b01, 1'b1, 2'b00);
        chk("t1_rlast_at_ar1", 32'(s_axi_rlast), 32'd1);
        wait_r();

        // ---- INCR burst, back-to-back beats ----
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; ed[i] = 32'(i + 1); end
        wr(32'h100, 8'd3, 2'b01, 1'b0, 2'b00);
        wait_b();
        rd(32'h100, 8'd3, 2'b01, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_rvalid_beat", 32'(s_axi_rvalid), 32'd1);
        end
        @(negedge clk);
        chk("t2_rvalid_done", 32'(s_axi_rvalid), 32'd0);
        wait_r();

        // ---- byte strobes and FIXED ----
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        wr(32'h20, 8'd0, 2'b01, 1'b0, 2'b00);
        wait_b();
        wd[0] = 32'h000000AA; ws[0] = 4'h1;
        wd[1] = 32'h0000BB00; ws[1] = 4'h2;
        wr(32'h20, 8'd1, 2'b00, 1'b1, 2'b00);
        wait_b();
        ed[0] = 32'hFFFFBBAA;
        rd(32'h20, 8'd0, 2'b01, 1'b0, 2'b00);
        wait_r();

        // ---- read backpressure: rready 1,0,0,1,1 ----
        s_axi_rready = 1'b0;
        ed[0] = 32'd1; ed[1] = 32'd2; ed[2] = 32'd3;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        rd(32'h100, 8'd2, 2'b01, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            s_axi_rready = pat[i];
            @(negedge clk);
            if (!pat[i]) begin
                chk("t4_stall_rvalid", 32'(s_axi_rvalid), 32'd1);
                chk("t4_stall_rdata", s_axi_rdata, 32'd2);
                chk("t4_stall_rlast", 32'(s_axi_rlast), 32'd0);
            end
            @(posedge clk); #1;
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        chk("t4_rvalid_done", 32'(s_axi_rvalid), 32'd0);
        chk("t4_beats", 32'(rq.size()), 32'd0);
        @(posedge clk); #1;

        // ---- B backpressure ----
        s_axi_bready = 1'b0;
        wd[0] = 32'h55; ws[0] = 4'hF;
        wr(32'h30, 8'd0, 2'b01, 1'b1, 2'b00);
        repeat (5) begin
            @(negedge clk);
            chk("t4_bvalid_held", 32'(s_axi_bvalid), 32'd1);
            chk("t4_awready_low", 32'(s_axi_awready), 32'd0);
        end
        @(posedge clk); #1;
        s_axi_bready = 1'b1;
        @(negedge clk);
        chk("t4_awready_at_b", 32'(s_axi_awready), 32'd0);
        @(posedge clk); #1;
        chk("t4_awready_after_b", 32'(s_axi_awready), 32'd1);
        chk("t4_bvalid_clear", 32'(s_axi_bvalid), 32'd0);
        chk("t4_b_popped", 32'(bq.size()), 32'd0);

        // ---- WRAP burst: error vs. treated as INCR ----
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        wr(32'h40, 8'd0, 2'b01, 1'b0, 2'b00);
        wait_b();
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        wr(32'h40, 8'd0, 2'b10, 1'b0, ERR_EN ? 2'b10 : 2'b00);
        wait_b();
        ed[0] = ERR_EN ? 32'h12345678 : 32'hCAFEF00D;
        rd(32'h40, 8'd0, 2'b01, 1'b0, 2'b00);
        wait_r();
        if (ERR_EN) begin
            ed[0] = 32'd0; ed[1] = 32'd0;
            rd(32'h40, 8'd1, 2'b10, 1'b1, 2'b10);
            wait_r();
        end

        // ---- reset during beat 2 of a len-3 read ----
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; ed[i] = 32'hA0 + 32'(i);
        end
        wr(32'h200, 8'd3, 2'b01, 1'b0, 2'b00);
        wait_b();
        rd(32'h200, 8'd3, 2'b01, 1'b0, 2'b00);
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("t6_rvalid_in_rst", 32'(s_axi_rvalid), 32'd0);
        chk("t6_arready_in_rst", 32'(s_axi_arready), 32'd0);
        chk("t6_beats_before_rst", 32'(rq.size()), 32'd2);
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("t6_arready_pre_edge", 32'(s_axi_arready), 32'd0);
        @(posedge clk); #1;
        chk("t6_arready_post_edge", 32'(s_axi_arready), 32'd1);
        ed[0] = 32'hA0;
        rd(32'h200, 8'd0, 2'b01, 1'b1, 2'b00);
        chk("t6_rlast_new_ar", 32'(s_axi_rlast), 32'd1);
        wait_r();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
